// File: rtl/z80_sys_pkg.sv
// Shared encodings for the Z80 clock/reset controller: CPU modes, controller
// states and the default reset-stretch length.
package z80_sys_pkg;

  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_STEP = 2'b01;
  localparam logic [1:0] MODE_HALT = 2'b10;

  localparam int RST_CYCLES_DEF = 8;

  typedef enum logic [1:0] {
    ST_RESET = 2'b00,
    ST_RUN   = 2'b01,
    ST_PARK  = 2'b10,
    ST_STEP  = 2'b11
  } clk_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: two-flop synchroniser followed by a stability counter;
// the output level follows the input only after DEB_CYCLES stable samples.
module btn_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic level_o
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;

  // Synchronise the raw button and flip the level after a stable run
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/z80_clk_rst_ctrl.sv
// Z80 CPU clock divider with run/step/halt control and stretched CPU reset.
// Step mode is built only when Z80_CLK_STEP_EN is defined; otherwise mode 01 halts.
module z80_clk_rst_ctrl
  import z80_sys_pkg::*;
#(
  parameter int DIV_W      = 16,
  parameter int RST_CYCLES = RST_CYCLES_DEF,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic             mclk,
  input  logic             nreset,
  input  logic [DIV_W-1:0] div_ratio,
  input  logic [1:0]       mode,
  input  logic             step_btn,
  input  logic             rst_btn,
  output logic             cpu_clk,
  output logic             cpu_clk_rise,
  output logic             cpu_nreset,
  output logic             step_busy
);

  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam logic [RW-1:0] RST_MAX = RW'(RST_CYCLES);

  clk_state_e       state_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] ratio_q;
  logic             ratio_vld_q;
  logic             clk_q;
  logic             rise_q;
  logic             nres_q;
  logic             busy_q;
  logic [RW-1:0]    rst_cnt_q;

  logic             rst_req_s;
  logic             step_req_s;
  logic [DIV_W-1:0] ratio_s;
  logic             toggle_s;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_rst_deb (
    .clk_i   (mclk),
    .rst_ni  (nreset),
    .btn_i   (rst_btn),
    .level_o (rst_req_s)
  );

`ifdef Z80_CLK_STEP_EN
  logic step_lvl_s;
  logic step_prev_q;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_deb (
    .clk_i   (mclk),
    .rst_ni  (nreset),
    .btn_i   (step_btn),
    .level_o (step_lvl_s)
  );

  // Remember the previous debounced step level for rising-edge detection
  always_ff @(posedge mclk or negedge nreset) begin
    if (!nreset) begin
      step_prev_q <= 1'b0;
    end else begin
      step_prev_q <= step_lvl_s;
    end
  end

  assign step_req_s = step_lvl_s & ~step_prev_q;
`else
  // Without step support the button is deliberately discarded
  assign step_req_s = 1'b0 & step_btn;
`endif

  // Until the first post-reset edge the ratio tracks the input directly
  assign ratio_s  = ratio_vld_q ? ratio_q : div_ratio;
  assign toggle_s = (cnt_q == ratio_s);

  // Clock/reset state machine: phase counter, CPU clock and reset stretch
  always_ff @(posedge mclk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= ST_RESET;
      cnt_q       <= '0;
      ratio_q     <= '0;
      ratio_vld_q <= 1'b0;
      clk_q       <= 1'b0;
      rise_q      <= 1'b0;
      nres_q      <= 1'b0;
      busy_q      <= 1'b0;
      rst_cnt_q   <= '0;
    end else begin
      rise_q      <= 1'b0;
      cnt_q       <= cnt_q + DIV_W'(1);
      ratio_vld_q <= 1'b1;
      if (toggle_s || !ratio_vld_q) begin
        ratio_q <= div_ratio;
      end else begin
        ratio_q <= ratio_q;
      end

      if (toggle_s) begin
        cnt_q <= '0;
        if (clk_q) begin
          clk_q <= 1'b0;
          case (state_q)
            ST_RESET: begin
              if (rst_cnt_q == RST_MAX) begin
                nres_q  <= 1'b1;
                state_q <= (mode == MODE_RUN) ? ST_RUN : ST_PARK;
              end
            end
            ST_STEP: begin
              state_q <= ST_PARK;
              busy_q  <= 1'b0;
            end
            default: begin
            end
          endcase
        end else begin
          case (state_q)
            ST_RUN: begin
              if (mode == MODE_RUN) begin
                clk_q  <= 1'b1;
                rise_q <= 1'b1;
              end else begin
                state_q <= ST_PARK;
              end
            end
            ST_PARK: begin
            end
            ST_RESET: begin
              clk_q  <= 1'b1;
              rise_q <= 1'b1;
              if (rst_cnt_q != RST_MAX) begin
                rst_cnt_q <= rst_cnt_q + RW'(1);
              end
            end
            default: begin
              clk_q  <= 1'b1;
              rise_q <= 1'b1;
            end
          endcase
        end
      end

      // Parked: hold the phase so a restart always begins with a full low phase
      if (state_q == ST_PARK) begin
        cnt_q <= '0;
        if (mode == MODE_RUN) begin
          state_q <= ST_RUN;
        end else if (step_req_s && (mode == MODE_STEP)) begin
          state_q <= ST_STEP;
          busy_q  <= 1'b1;
        end
      end

      if (rst_req_s) begin
        state_q   <= ST_RESET;
        rst_cnt_q <= '0;
        nres_q    <= 1'b0;
        busy_q    <= 1'b0;
      end
    end
  end

  assign cpu_clk      = clk_q;
  assign cpu_clk_rise = rise_q;
  assign cpu_nreset   = nres_q;
  assign step_busy    = busy_q;

endmodule

// File: tb/tb_z80_clk_rst_ctrl.sv
// Directed bench for z80_clk_rst_ctrl with DEB_CYCLES=4, RST_CYCLES=4, ratio 3.
module tb_z80_clk_rst_ctrl;

  logic        mclk = 1'b0;
  logic        nreset;
  logic [15:0] div_ratio;
  logic [1:0]  mode;
  logic        step_btn;
  logic        rst_btn;
  logic        cpu_clk;
  logic        cpu_clk_rise;
  logic        cpu_nreset;
  logic        step_busy;

  int checks = 0;
  int errors = 0;

  always #5 mclk = ~mclk;

  z80_clk_rst_ctrl #(
    .DIV_W      (16),
    .RST_CYCLES (4),
    .DEB_CYCLES (4)
  ) dut (
    .mclk         (mclk),
    .nreset       (nreset),
    .div_ratio    (div_ratio),
    .mode         (mode),
    .step_btn     (step_btn),
    .rst_btn      (rst_btn),
    .cpu_clk      (cpu_clk),
    .cpu_clk_rise (cpu_clk_rise),
    .cpu_nreset   (cpu_nreset),
    .step_busy    (step_busy)
  );

  task automatic tick;
    @(posedge mclk);
    #1;
  endtask

  task automatic test_reset;
    logic exp_clk, exp_rise, exp_nres;
    nreset = 1'b0; mode = 2'b00; div_ratio = 16'd3; step_btn = 1'b0; rst_btn = 1'b0;
    repeat (3) tick;
    checks++; if (cpu_clk !== 1'b0) begin errors++; $display("FAIL reset_clk: got %b want 0", cpu_clk); end
    checks++; if (cpu_clk_rise !== 1'b0) begin errors++; $display("FAIL reset_rise: got %b want 0", cpu_clk_rise); end
    checks++; if (cpu_nreset !== 1'b0) begin errors++; $display("FAIL reset_nres: got %b want 0", cpu_nreset); end
    checks++; if (step_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", step_busy); end
    nreset = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick;
      exp_clk  = (k >= 4) && (((k - 4) % 8) < 4);
      exp_rise = (k >= 4) && (((k - 4) % 8) == 0);
      exp_nres = (k >= 32);
      checks++; if (cpu_clk !== exp_clk) begin errors++; $display("FAIL release_clk k=%0d: got %b want %b", k, cpu_clk, exp_clk); end
      checks++; if (cpu_clk_rise !== exp_rise) begin errors++; $display("FAIL release_rise k=%0d: got %b want %b", k, cpu_clk_rise, exp_rise); end
      checks++; if (cpu_nreset !== exp_nres) begin errors++; $display("FAIL release_nres k=%0d: got %b want %b", k, cpu_nreset, exp_nres); end
    end
  endtask

  task automatic test_halt;
    int n;
    logic exp_clk;
    n = 0;
    while (cpu_clk_rise !== 1'b1 && n < 20) begin tick; n++; end
    checks++; if (cpu_clk_rise !== 1'b1) begin errors++; $display("FAIL halt_wait_rise: got %b want 1", cpu_clk_rise); end
    mode = 2'b10;
    for (int t = 1; t <= 24; t++) begin
      tick;
      exp_clk = (t < 4);
      checks++; if (cpu_clk !== exp_clk) begin errors++; $display("FAIL halt_clk t=%0d: got %b want %b", t, cpu_clk, exp_clk); end
      checks++; if (cpu_clk_rise !== 1'b0) begin errors++; $display("FAIL halt_rise t=%0d: got %b want 0", t, cpu_clk_rise); end
    end
  endtask

`ifdef Z80_CLK_STEP_EN
  task automatic test_step;
    int rises, busy_n, first_busy, falls;
    logic prev_clk, prev_busy;
    // single press at ratio 3
    mode = 2'b01;
    repeat (4) tick;
    step_btn = 1'b1;
    rises = 0; busy_n = 0; first_busy = 0; falls = 0;
    prev_clk = cpu_clk; prev_busy = step_busy;
    for (int t = 1; t <= 30; t++) begin
      tick;
      if (t == 6) step_btn = 1'b0;
      if (cpu_clk_rise === 1'b1) rises++;
      if (step_busy === 1'b1) begin busy_n++; if (first_busy == 0) first_busy = t; end
      if (prev_clk === 1'b1 && cpu_clk === 1'b0) begin
        falls++;
        checks++; if (step_busy !== 1'b0 || prev_busy !== 1'b1) begin errors++; $display("FAIL step_fall_busy t=%0d: got busy %b (before %b) want 0 (before 1)", t, step_busy, prev_busy); end
      end
      prev_clk = cpu_clk; prev_busy = step_busy;
    end
    checks++; if (rises != 1) begin errors++; $display("FAIL step_rises: got %0d want 1", rises); end
    checks++; if (busy_n != 8) begin errors++; $display("FAIL step_busy_len: got %0d want 8", busy_n); end
    checks++; if (first_busy != 7) begin errors++; $display("FAIL step_busy_start: got %0d want 7", first_busy); end
    checks++; if (falls != 1) begin errors++; $display("FAIL step_falls: got %0d want 1", falls); end
    // longer ratio so a second debounced press lands inside the busy window
    mode = 2'b00; div_ratio = 16'd7;
    repeat (40) tick;
    mode = 2'b01;
    repeat (40) tick;
    checks++; if (cpu_clk !== 1'b0) begin errors++; $display("FAIL step_parked: got %b want 0", cpu_clk); end
    step_btn = 1'b1;
    rises = 0; busy_n = 0; falls = 0;
    prev_clk = cpu_clk;
    for (int t = 1; t <= 45; t++) begin
      tick;
      if (t == 6)  step_btn = 1'b0;
      if (t == 13) step_btn = 1'b1;
      if (t == 19) step_btn = 1'b0;
      if (cpu_clk_rise === 1'b1) rises++;
      if (step_busy === 1'b1) busy_n++;
      if (prev_clk === 1'b1 && cpu_clk === 1'b0) falls++;
      prev_clk = cpu_clk;
    end
    checks++; if (rises != 1) begin errors++; $display("FAIL step2_rises: got %0d want 1", rises); end
    checks++; if (busy_n != 16) begin errors++; $display("FAIL step2_busy_len: got %0d want 16", busy_n); end
    checks++; if (falls != 1) begin errors++; $display("FAIL step2_falls: got %0d want 1", falls); end
    div_ratio = 16'd3; mode = 2'b00;
  endtask
`else
  task automatic test_step;
    int rises, busy_n, high_n;
    mode = 2'b01;
    repeat (4) tick;
    step_btn = 1'b1;
    rises = 0; busy_n = 0; high_n = 0;
    for (int t = 1; t <= 30; t++) begin
      tick;
      if (t == 6) step_btn = 1'b0;
      if (cpu_clk_rise === 1'b1) rises++;
      if (step_busy !== 1'b0) busy_n++;
      if (cpu_clk !== 1'b0) high_n++;
    end
    checks++; if (rises != 0) begin errors++; $display("FAIL nostep_rises: got %0d want 0", rises); end
    checks++; if (busy_n != 0) begin errors++; $display("FAIL nostep_busy: got %0d want 0", busy_n); end
    checks++; if (high_n != 0) begin errors++; $display("FAIL nostep_clk_high: got %0d want 0", high_n); end
    div_ratio = 16'd3; mode = 2'b00;
  endtask
`endif

  task automatic test_rst_btn;
    int rel_t, rises;
    logic low_ok, prev_clk, fell_at_rel;
    repeat (50) tick;
    checks++; if (cpu_nreset !== 1'b1) begin errors++; $display("FAIL rstbtn_pre: got %b want 1", cpu_nreset); end
    rst_btn = 1'b1;
    repeat (3) tick;
    rst_btn = 1'b0;
    for (int t = 1; t <= 20; t++) begin
      tick;
      checks++; if (cpu_nreset !== 1'b1) begin errors++; $display("FAIL rstbtn_short t=%0d: got %b want 1", t, cpu_nreset); end
    end
    rst_btn = 1'b1;
    rel_t = 0; rises = 0; low_ok = 1'b1; fell_at_rel = 1'b0;
    prev_clk = cpu_clk;
    for (int t = 1; t <= 120 && rel_t == 0; t++) begin
      tick;
      if (t == 10) rst_btn = 1'b0;
      if (t == 6) begin
        checks++; if (cpu_nreset !== 1'b1) begin errors++; $display("FAIL rstbtn_e6: got %b want 1", cpu_nreset); end
      end
      if (t == 7) begin
        checks++; if (cpu_nreset !== 1'b0) begin errors++; $display("FAIL rstbtn_e7: got %b want 0", cpu_nreset); end
      end
      if (t >= 17 && cpu_clk_rise === 1'b1) rises++;
      if (t > 7 && t < 17 && cpu_nreset !== 1'b0) low_ok = 1'b0;
      if (t >= 17 && cpu_nreset === 1'b1) begin
        rel_t = t;
        fell_at_rel = (prev_clk === 1'b1) && (cpu_clk === 1'b0);
      end
      prev_clk = cpu_clk;
    end
    checks++; if (rel_t == 0) begin errors++; $display("FAIL rstbtn_release_timeout: got no release want release within 120"); end
    checks++; if (low_ok !== 1'b1) begin errors++; $display("FAIL rstbtn_held_low: got early release want low"); end
    checks++; if (rises != 4) begin errors++; $display("FAIL rstbtn_rises: got %0d want 4", rises); end
    checks++; if (fell_at_rel !== 1'b1) begin errors++; $display("FAIL rstbtn_release_on_fall: got %b want 1", fell_at_rel); end
  endtask

  task automatic test_div_change;
    int n;
    logic exp_clk, exp_rise;
    n = 0;
    while (cpu_clk_rise !== 1'b1 && n < 20) begin tick; n++; end
    checks++; if (cpu_clk_rise !== 1'b1) begin errors++; $display("FAIL div_wait_rise: got %b want 1", cpu_clk_rise); end
    for (int t = 1; t <= 12; t++) begin
      tick;
      if (t == 1) div_ratio = 16'd0;
      exp_clk  = (t < 4) ? 1'b1 : (((t - 4) % 2) == 1);
      exp_rise = (t >= 5) && (((t - 4) % 2) == 1);
      checks++; if (cpu_clk !== exp_clk) begin errors++; $display("FAIL div_clk t=%0d: got %b want %b", t, cpu_clk, exp_clk); end
      checks++; if (cpu_clk_rise !== exp_rise) begin errors++; $display("FAIL div_rise t=%0d: got %b want %b", t, cpu_clk_rise, exp_rise); end
    end
  endtask

  task automatic test_async_reset;
    int n;
    n = 0;
    while (cpu_clk !== 1'b1 && n < 10) begin tick; n++; end
    checks++; if (cpu_clk !== 1'b1) begin errors++; $display("FAIL async_wait_high: got %b want 1", cpu_clk); end
    #3;
    nreset = 1'b0;
    #1;
    checks++; if (cpu_clk !== 1'b0) begin errors++; $display("FAIL async_clk: got %b want 0", cpu_clk); end
    checks++; if (cpu_nreset !== 1'b0) begin errors++; $display("FAIL async_nres: got %b want 0", cpu_nreset); end
    checks++; if (cpu_clk_rise !== 1'b0) begin errors++; $display("FAIL async_rise: got %b want 0", cpu_clk_rise); end
    checks++; if (step_busy !== 1'b0) begin errors++; $display("FAIL async_busy: got %b want 0", step_busy); end
  endtask

  initial begin
    test_reset;
    test_halt;
    test_step;
    test_rst_btn;
    test_div_change;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/z80_clk_rst_ctrl.md
# z80_clk_rst_ctrl

Parametrised Z80 clock and reset controller. It sits between the board oscillator (`mclk`) and the Z80 core. It generates the CPU clock with a runtime-programmable divide ratio and supports run, single-step and halt modes. It also produces a debounced, stretched CPU reset that guarantees a minimum number of CPU clock cycles with `nRESET` low.

## Interface
- `DIV_W`, 16: width of divide-ratio input and phase counter.
- `RST_CYCLES`, 8: CPU clock rising edges with `cpu_nreset` low per reset sequence (min 3).
- `DEB_CYCLES`, 1_000_000: mclk cycles a button must be stable before its debounced level changes.

Ports:
- `mclk`  in  1  master clock; sole clock.
- `nreset`  in  1  asynchronous, active-low reset.
- `div_ratio`  in  DIV_W  half-period minus one, in mclk cycles.
- `mode`  in  2  00 run, 01 step, 10/11 halt.
- `step_btn`  in  1  raw asynchronous step button, active high.
- `rst_btn`  in  1  raw asynchronous CPU reset button, active high.
- `cpu_clk`  out  1  registered CPU clock.
- `cpu_clk_rise`  out  1  one-mclk pulse, high in the same cycle `cpu_clk` becomes 1.
- `cpu_nreset`  out  1  active-low CPU reset, registered.
- `step_busy`  out  1  step request accepted, cycle not yet complete.

## Operation
- States: RESET, RUN, PARK, STEP.
- While `nreset` is low: state RESET; `cpu_clk`=0, `cpu_clk_rise`=0, `cpu_nreset`=0, `step_busy`=0; all counters 0; latched ratio = `div_ratio`.
- Phase counter `cnt` increments each mclk.
  - When `cnt`==latched ratio, `cnt`→0 and a toggle point occurs.
  - `div_ratio` is re-latched at every toggle point.
  - div_ratio=0 gives `cpu_clk` = mclk/2.
- Toggle point with `cpu_clk`=1: `cpu_clk`→0 unconditionally. The high phase is never truncated.
- Toggle point with `cpu_clk`=0 (decision point):
  - RESET, RUN, STEP: `cpu_clk`→1.
  - PARK: `cpu_clk` stays 0 and `cnt` is held at 0.
- RESET: the clock is forced running regardless of `mode`.
  - `rst_cnt` counts `cpu_clk_rise` pulses.
  - After the RST_CYCLES-th rise, on the following high→low toggle, `cpu_nreset`→1 and the state moves to RUN (mode 00) or PARK (otherwise).
- RUN: a decision point with mode≠00 → PARK; `cpu_clk` stays low.
- PARK: mode 00 → RUN at the next mclk; `cnt` restarts from 0, giving a full low phase.
- PARK + debounced `step_btn` rising edge + mode 01 → STEP.
  - `step_busy`=1.
  - The CPU gets exactly one full cycle: low phase, high phase, then a falling edge.
  - Return to PARK; `step_busy`=0 in the same cycle `cpu_clk` falls.
- Step presses in any state other than PARK+mode 01 are dropped. There is no queueing.
- Debounced `rst_btn` high, in any state: state RESET and `rst_cnt`=0 at the next mclk; `cpu_nreset`→0 at that edge. While the button stays high, `rst_cnt` is held at 0, so counting starts after release.
- `nreset` asserted mid-operation: immediate async return to reset values, including a mid-high-phase `cpu_clk`.

## Timing
- Button path: 2-flop synchroniser + DEB_CYCLES stability counter. The debounced edge appears DEB_CYCLES+2 mclk after the stable input change.
- Half period = latched ratio + 1 mclk. Full CPU period = 2×(ratio+1).
- `cpu_clk_rise` and `cpu_clk` rise on the same mclk edge.
- `cpu_nreset` changes only on high→low `cpu_clk` toggles (release) or on mclk (assert).
- Reset release latency after `nreset` deasserts: RST_CYCLES full CPU periods.

## Configuration
- `Z80_CLK_STEP_EN`: defined → step mode as above.
- Undefined → mode 01 behaves as halt; `step_btn` is ignored; `step_busy` is tied 0; no debouncer instance for `step_btn`.

## Structure
- Package `z80_sys_pkg` holds:
  - mode encodings `MODE_RUN`/`MODE_STEP`/`MODE_HALT`
  - state encodings
  - default `RST_CYCLES` constant
- Sub-module `btn_debounce` (synchroniser + stability counter, parameter `DEB_CYCLES`), instantiated once per button.

## Test plan
Bench parameters: DEB_CYCLES=4, RST_CYCLES=4, div_ratio=3.
- Release `nreset`, mode 00 → `cpu_clk` period 8 mclk; `cpu_nreset` rises on the 4th falling `cpu_clk`, exactly 32 mclk after release.
- Mode 00 → 10 while `cpu_clk` high → high phase completes (4 mclk), then `cpu_clk` parks low; `cpu_clk_rise` stays 0.
- Mode 01, parked: step press stable 6 mclk → exactly one `cpu_clk_rise` pulse; `step_busy` high for 8 mclk; a second press during busy produces no extra edge.
- `rst_btn` pulse of 3 mclk (shorter than debounce) → no effect; pulse of 10 mclk → `cpu_nreset` low, then high again 4 CPU periods after debounced release.
- `div_ratio` changed 3→0 mid-phase → current half-period stays 4 mclk; subsequent half-periods are 1 mclk.
- `nreset` asserted while `cpu_clk`=1 → `cpu_clk`=0 and `cpu_nreset`=0 immediately (asynchronously).
